// File: rtl/prm_edge_sweep_if.sv
// Word output channel from the edge sweeper to the roadmap-memory writer.
// Handshake: a word transfers on any rising edge where word_valid_o and
// word_ready_i are both 1. Once word_valid_o rises, word_o and word_addr_o
// hold steady until that transfer happens; word_ready_i may change freely.
interface prm_edge_sweep_if;
  logic [31:0] word_o;
  logic [9:0]  word_addr_o;
  logic        word_valid_o;
  logic        word_ready_i;

  modport master (
    output word_o,
    output word_addr_o,
    output word_valid_o,
    input  word_ready_i
  );

  modport slave (
    input  word_o,
    input  word_addr_o,
    input  word_valid_o,
    output word_ready_i
  );
endinterface

// File: rtl/prm_edge_sweep.sv
// PRM edge sweeper: steps through all 32768 edge codes, ORs the enabled
// obstacle checker returns for each code and packs one bit per code into
// 32-bit words handed downstream through a single-entry output buffer.
module prm_edge_sweep #(
  parameter int NUM_OBS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_OBS-1:0] obs_en,
  output logic [14:0]        code_o,
  input  logic [NUM_OBS-1:0] mask_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        blocked_cnt_o,
  output logic [1:0]         state_o,
  prm_edge_sweep_if.master   wr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [NUM_OBS-1:0] obs_en_q;
  logic [14:0]        code_q;
  logic [31:0]        pack_q;
  logic [31:0]        word_q;
  logic [9:0]         addr_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic [15:0]        blocked_q;

  logic               hit_d;
  logic               boundary_d;
  logic               buf_free_d;
  logic [31:0]        word_d;
  logic [15:0]        blocked_d;

  // Per-code result and the word that would be emitted at a 32-code boundary.
  always_comb begin
    hit_d      = |(mask_i & obs_en_q);
    boundary_d = (code_q[4:0] == 5'd31);
    // Buffer can take a new word if empty or being drained this same edge.
    buf_free_d = !valid_q || wr.word_ready_i;
    // The boundary code is always bit 31, so its hit goes straight in.
    word_d     = pack_q;
    word_d[31] = hit_d;
    blocked_d  = blocked_q + {15'd0, hit_d};
  end

  // Sweep FSM, pack register, output buffer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      obs_en_q  <= '0;
      code_q    <= '0;
      pack_q    <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      blocked_q <= '0;
    end else begin
      // Accepted word leaves the buffer unless a reload below overrides it.
      if (valid_q && wr.word_ready_i) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            obs_en_q  <= obs_en;
            code_q    <= '0;
            pack_q    <= '0;
            blocked_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (!boundary_d) begin
            pack_q[code_q[4:0]] <= hit_d;
            blocked_q           <= blocked_d;
            code_q              <= code_q + 15'd1;
          end else if (buf_free_d) begin
            word_q    <= word_d;
            addr_q    <= code_q[14:5];
            valid_q   <= 1'b1;
            pack_q    <= '0;
            blocked_q <= blocked_d;
            // Wraps to 0 after the last code; value is irrelevant in DRAIN.
            code_q    <= code_q + 15'd1;
            if (&code_q[14:5]) begin
              state_q <= ST_DRAIN;
            end
          end
          // Boundary with a full, unaccepted buffer: hold everything and
          // re-evaluate the same code next cycle.
        end

        ST_DRAIN: begin
          // Leave as soon as the final word is gone (or goes this edge).
          if (!valid_q || wr.word_ready_i) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign code_o          = code_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign blocked_cnt_o   = blocked_q;
  assign state_o         = state_q;
  assign wr.word_o       = word_q;
  assign wr.word_addr_o  = addr_q;
  assign wr.word_valid_o = valid_q;

endmodule

// File: tb/tb_prm_edge_sweep.sv
// Bench for prm_edge_sweep: stub checkers driven from code_o, directed
// scenarios with hand-derived expected words, counts and timings.
module tb_prm_edge_sweep;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  obs_en;
  logic [14:0] code_o;
  logic [7:0]  mask_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] blocked_cnt_o;
  logic [1:0]  state_o;

  prm_edge_sweep_if wr_if();

  prm_edge_sweep #(.NUM_OBS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .obs_en        (obs_en),
    .code_o        (code_o),
    .mask_i        (mask_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .blocked_cnt_o (blocked_cnt_o),
    .state_o       (state_o),
    .wr            (wr_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub obstacle checkers: obs0 hits code 5 only, obs1 hits the upper
  // half of the code space, obs2 hits every odd code.
  function automatic logic [7:0] stub_mask(input logic [14:0] c);
    logic [7:0] m;
    m    = '0;
    m[0] = (c == 15'd5);
    m[1] = c[14];
    m[2] = c[0];
    return m;
  endfunction

  always_comb mask_i = stub_mask(code_o);

  // Reference word for an address under a given enable mask.
  function automatic logic [31:0] model_word(input int addr, input logic [7:0] en);
    logic [31:0] w;
    logic [14:0] c;
    logic [9:0]  a;
    a = addr[9:0];
    for (int i = 0; i < 32; i++) begin
      c    = {a, i[4:0]};
      w[i] = |(stub_mask(c) & en);
    end
    return w;
  endfunction

  // Scoreboard capture: accepted words and done pulses
  logic [31:0] acc_word_q[$];
  logic [9:0]  acc_addr_q[$];
  int          done_count = 0;
  int          done_cyc = 0;
  bit          done_prev = 0;
  bit          done_long = 0;

  always @(negedge clk) begin
    if (wr_if.word_valid_o && wr_if.word_ready_i) begin
      acc_word_q.push_back(wr_if.word_o);
      acc_addr_q.push_back(wr_if.word_addr_o);
    end
    if (done_o) begin
      done_count++;
      done_cyc = cyc;
      if (done_prev) done_long = 1;
    end
    done_prev = done_o;
  end

  // Driver: pulse start for one edge; returns cyc at the cycle-1 negedge.
  task automatic pulse_start(input logic [7:0] en, output int t0);
    @(posedge clk);
    #1 obs_en = en;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    t0 = cyc;
  endtask

  task automatic clear_sb();
    acc_word_q.delete();
    acc_addr_q.delete();
    done_count = 0;
    done_long  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (code_o !== 15'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl code=%0d busy=%b done=%b want 0/0/0", code_o, busy_o, done_o);
    end
    checks++;
    if (wr_if.word_o !== 32'd0 || wr_if.word_addr_o !== 10'd0 || wr_if.word_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_word word=%h addr=%0d valid=%b want 0/0/0",
               wr_if.word_o, wr_if.word_addr_o, wr_if.word_valid_o);
    end
    checks++;
    if (blocked_cnt_o !== 16'd0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt blocked=%0d state=%0d want 0/0", blocked_cnt_o, state_o);
    end
    #1 rst = 1'b0;
  endtask

  // Zero enables for the first 1000 codes, then reset mid-sweep.
  task automatic test_reset_mid_sweep();
    int  t0;
    bit  hit;
    clear_sb();
    wr_if.word_ready_i = 1'b1;
    pulse_start(8'h00, t0);
    checks++;
    if (busy_o !== 1'b1 || code_o !== 15'd0) begin
      errors++;
      $display("FAIL zero_start busy=%b code=%0d want 1/0", busy_o, code_o);
    end
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      if (code_o == 15'd1000) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_code_1000 code=%0d want 1000", code_o);
    end
    checks++;
    if (acc_word_q.size() != 31) begin
      errors++;
      $display("FAIL zero_word_count got=%0d want 31", acc_word_q.size());
    end
    for (int i = 0; i < acc_word_q.size(); i++) begin
      checks++;
      if (acc_word_q[i] !== 32'd0 || acc_addr_q[i] !== 10'(i)) begin
        errors++;
        $display("FAIL zero_word[%0d] word=%h addr=%0d want 00000000/%0d",
                 i, acc_word_q[i], acc_addr_q[i], i);
      end
    end
    checks++;
    if (blocked_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL zero_blocked got=%0d want 0", blocked_cnt_o);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (code_o !== 15'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || state_o !== 2'd0 ||
        wr_if.word_valid_o !== 1'b0 || wr_if.word_o !== 32'd0 ||
        wr_if.word_addr_o !== 10'd0 || blocked_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL midrst_state code=%0d busy=%b done=%b st=%0d valid=%b word=%h addr=%0d blk=%0d want all 0",
               code_o, busy_o, done_o, state_o, wr_if.word_valid_o, wr_if.word_o,
               wr_if.word_addr_o, blocked_cnt_o);
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_count != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_done done_count=%0d busy=%b want 0/0", done_count, busy_o);
    end
  endtask

  // Single hit with word 0 held back 100+ cycles and a start pulse with a
  // different mask during the scan.
  task automatic test_backpressure_start_busy();
    int  t0;
    bit  got;
    logic [31:0] exp;
    clear_sb();
    wr_if.word_ready_i = 1'b0;
    pulse_start(8'h01, t0);
    checks++;
    if (busy_o !== 1'b1 || code_o !== 15'd0) begin
      errors++;
      $display("FAIL restart_at_zero busy=%b code=%0d want 1/0", busy_o, code_o);
    end
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (wr_if.word_valid_o) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got || (cyc - t0 + 1) != 33) begin
      errors++;
      $display("FAIL word0_latency seen=%b cycle=%0d want 1/33", got, cyc - t0 + 1);
    end
    checks++;
    if (wr_if.word_o !== 32'h0000_0020 || wr_if.word_addr_o !== 10'd0) begin
      errors++;
      $display("FAIL word0_value word=%h addr=%0d want 00000020/0", wr_if.word_o, wr_if.word_addr_o);
    end
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 50) begin
        obs_en = 8'hFF;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (wr_if.word_valid_o !== 1'b1 || wr_if.word_o !== 32'h0000_0020 ||
          wr_if.word_addr_o !== 10'd0) begin
        errors++;
        $display("FAIL hold_stable[%0d] valid=%b word=%h addr=%0d want 1/00000020/0",
                 k, wr_if.word_valid_o, wr_if.word_o, wr_if.word_addr_o);
      end
    end
    checks++;
    if (code_o !== 15'd63 || acc_word_q.size() != 0) begin
      errors++;
      $display("FAIL stall_at_63 code=%0d accepted=%0d want 63/0", code_o, acc_word_q.size());
    end
    @(posedge clk);
    #1 wr_if.word_ready_i = 1'b1;
    got = 0;
    for (int k = 0; k < 40000 && !got; k++) begin
      @(negedge clk);
      if (done_count != 0) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bp_done_timeout done_count=%0d want 1", done_count);
    end
    checks++;
    if (busy_o !== 1'b0 || blocked_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL bp_done_state busy=%b blocked=%0d want 0/1", busy_o, blocked_cnt_o);
    end
    checks++;
    if (acc_word_q.size() != 1024) begin
      errors++;
      $display("FAIL bp_word_count got=%0d want 1024", acc_word_q.size());
    end
    for (int i = 0; i < acc_word_q.size(); i++) begin
      exp = model_word(i, 8'h01);
      checks++;
      if (acc_word_q[i] !== exp || acc_addr_q[i] !== 10'(i)) begin
        errors++;
        $display("FAIL bp_word[%0d] word=%h addr=%0d want %h/%0d",
                 i, acc_word_q[i], acc_addr_q[i], exp, i);
      end
    end
    checks++;
    if (acc_addr_q.size() == 0 || acc_addr_q[acc_addr_q.size()-1] !== 10'd1023) begin
      errors++;
      $display("FAIL bp_last_addr got=%0d want 1023",
               acc_addr_q.size() == 0 ? -1 : int'(acc_addr_q[acc_addr_q.size()-1]));
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_count != 1 || done_long || done_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_done_pulse count=%0d long=%b done=%b want 1/0/0", done_count, done_long, done_o);
    end
    checks++;
    if (blocked_cnt_o !== 16'd1 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL bp_idle_hold blocked=%0d state=%0d want 1/0", blocked_cnt_o, state_o);
    end
  endtask

  // Upper-half checker enabled, ready tied high: exact completion timing.
  task automatic test_enable_masking();
    int  t0;
    bit  got;
    logic [31:0] exp;
    clear_sb();
    wr_if.word_ready_i = 1'b1;
    pulse_start(8'h02, t0);
    got = 0;
    for (int k = 0; k < 40000 && !got; k++) begin
      @(negedge clk);
      if (done_count != 0) got = 1;
    end
    checks++;
    if (!got || (done_cyc - t0 + 1) != 32770) begin
      errors++;
      $display("FAIL mask_done_cycle seen=%b cycle=%0d want 1/32770", got, done_cyc - t0 + 1);
    end
    checks++;
    if (busy_o !== 1'b0 || blocked_cnt_o !== 16'd16384) begin
      errors++;
      $display("FAIL mask_done_state busy=%b blocked=%0d want 0/16384", busy_o, blocked_cnt_o);
    end
    checks++;
    if (acc_word_q.size() != 1024) begin
      errors++;
      $display("FAIL mask_word_count got=%0d want 1024", acc_word_q.size());
    end else begin
      checks++;
      if (acc_word_q[511] !== 32'h0000_0000 || acc_word_q[512] !== 32'hFFFF_FFFF ||
          acc_word_q[1023] !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL mask_half w511=%h w512=%h w1023=%h want 00000000/ffffffff/ffffffff",
                 acc_word_q[511], acc_word_q[512], acc_word_q[1023]);
      end
    end
    for (int i = 0; i < acc_word_q.size(); i++) begin
      exp = model_word(i, 8'h02);
      checks++;
      if (acc_word_q[i] !== exp || acc_addr_q[i] !== 10'(i)) begin
        errors++;
        $display("FAIL mask_word[%0d] word=%h addr=%0d want %h/%0d",
                 i, acc_word_q[i], acc_addr_q[i], exp, i);
      end
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || blocked_cnt_o !== 16'd16384 || done_count != 1) begin
      errors++;
      $display("FAIL mask_after_done done=%b blocked=%0d count=%0d want 0/16384/1",
               done_o, blocked_cnt_o, done_count);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    obs_en = 8'h00;
    wr_if.word_ready_i = 1'b1;
    test_reset();
    test_reset_mid_sweep();
    test_backpressure_start_busy();
    test_enable_masking();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
